// File: rtl/m_mem_arbiter_pkg.sv
// Shared codes for the M-stage data-memory arbiter: access types, FSM states, latched request.
package m_mem_arbiter_pkg;

  // Access-type codes carried on cpu_type (same encoding as Define.v)
  localparam logic [1:0] DM_sw = 2'd0;
  localparam logic [1:0] DM_sh = 2'd1;
  localparam logic [1:0] DM_sb = 2'd2;

  // Arbiter FSM state codes
  localparam logic [1:0] MA_IDLE = 2'd0;
  localparam logic [1:0] MA_BUSY = 2'd1;
  localparam logic [1:0] MA_DONE = 2'd2;

  // Request captured at grant time and replayed to DM during BUSY
  typedef struct packed {
    logic        owner_dma;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ma_req_t;

endpackage

// File: rtl/m_mem_arbiter_lane.sv
// Byte-lane steering for CPU accesses: type + low address bits -> byte enables and replicated data.
module m_arb_lane
  import m_mem_arbiter_pkg::*;
(
  input  logic [1:0]  typ,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [3:0]  byteen,
  output logic [31:0] wdata_rep
);

  // Select lanes and replicate the right-aligned store data across them; reads enable nothing
  always_comb begin
    byteen    = 4'b1111;
    wdata_rep = wdata;
    case (typ)
      DM_sh: begin
        byteen    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      DM_sb: begin
        byteen    = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      default: ;
    endcase
    if (!we) byteen = 4'b0000;
  end

endmodule

// File: rtl/m_mem_arbiter.sv
// M-stage data-memory arbiter: shares the DM port between CPU and DMA, sequences MEM_LAT-cycle
// accesses with a starvation guard for DMA. Optional macro ALIGN_CHK_EN enables the
// misaligned-access check on CPU requests.
module m_mem_arbiter
  import m_mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_type,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  output logic        cpu_exc,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  ma_req_t       req_q, req_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   dma_rdata_q, dma_rdata_d;

  logic [3:0]    lane_be;
  logic [31:0]   lane_wd;
  logic          cpu_elig, dma_win, busy, last;
  logic [1:0]    unused_dma_lo;

  assign unused_dma_lo = dma_addr[1:0];

  m_arb_lane u_lane (
    .typ       (cpu_type),
    .addr_lo   (cpu_addr[1:0]),
    .we        (cpu_we),
    .wdata     (cpu_wdata),
    .byteen    (lane_be),
    .wdata_rep (lane_wd)
  );

`ifdef ALIGN_CHK_EN
  assign cpu_exc = cpu_req & (((cpu_type == DM_sw) & (cpu_addr[1:0] != 2'b00)) |
                              ((cpu_type == DM_sh) & cpu_addr[0]));
`else
  assign cpu_exc = 1'b0;
`endif

  // A flagged CPU request is handed to the exception unit, never to memory
  assign cpu_elig = cpu_req & ~cpu_exc;
  assign dma_win  = dma_req & (~cpu_elig | (streak_q == SW'(STARVE_MAX)));
  assign busy     = (state_q == MA_BUSY);
  assign last     = busy & (cnt_q == '0);

  // Grant, countdown and read-capture sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    req_d       = req_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      MA_IDLE: begin
        if (cpu_elig | dma_req) begin
          state_d = MA_BUSY;
          cnt_d   = CW'(MEM_LAT - 1);
          if (dma_win) begin
            req_d.owner_dma = 1'b1;
            req_d.we        = dma_we;
            req_d.byteen    = dma_we ? 4'b1111 : 4'b0000;
            req_d.addr      = {dma_addr[31:2], 2'b00};
            req_d.wdata     = dma_wdata;
            streak_d        = '0;
          end else begin
            req_d.owner_dma = 1'b0;
            req_d.we        = cpu_we;
            req_d.byteen    = lane_be;
            req_d.addr      = {cpu_addr[31:2], 2'b00};
            req_d.wdata     = lane_wd;
            if (!dma_req)                          streak_d = '0;
            else if (streak_q != SW'(STARVE_MAX)) streak_d = streak_q + 1'b1;
          end
        end
      end
      MA_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MA_DONE;
          if (req_q.owner_dma) dma_rdata_d = mem_rdata;
          else                 cpu_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MA_IDLE;
    endcase
  end

  // State and latch registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MA_IDLE;
      cnt_q       <= '0;
      streak_q    <= '0;
      req_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      req_q       <= req_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign mem_addr   = busy ? req_q.addr   : 32'h0;
  assign mem_wdata  = busy ? req_q.wdata  : 32'h0;
  assign mem_byteen = busy ? req_q.byteen : 4'h0;
  assign mem_we     = last & req_q.we;
  assign cpu_done   = (state_q == MA_DONE) & ~req_q.owner_dma;
  assign dma_done   = (state_q == MA_DONE) &  req_q.owner_dma;
  assign cpu_stall  = cpu_req & ~cpu_done & ~cpu_exc;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Scoreboard bench for m_mem_arbiter (MEM_LAT=2, STARVE_MAX=3): drivers push expected writes and
// completions with their cycle numbers; a negedge monitor pops and compares on mem_we / done.
module tb_m_mem_arbiter;
  import m_mem_arbiter_pkg::*;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [1:0]  cpu_type = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_done, cpu_stall, cpu_exc, dma_done, mem_we;
  logic [3:0]  mem_byteen;

  int nerr = 0, nchk = 0, cyc = 0;

  typedef struct { bit dma; bit chk_rd; logic [31:0] rdata; int cyc; } done_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int cyc; } wr_t;
  done_t dq[$];
  wr_t   wq[$];

  m_mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .cpu_exc(cpu_exc), .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_done(dma_done), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe and every done pulse must match the head of its queue
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_we: addr %h at cyc %0d", mem_addr, cyc);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_wdata, w.wdata);
          chk("wr_byteen", {28'h0, mem_byteen}, {28'h0, w.be});
          chk("wr_cycle", cyc, w.cyc);
        end
      end
      if (cpu_done || dma_done) begin
        if (dq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_done: cpu %0b dma %0b at cyc %0d", cpu_done, dma_done, cyc);
        end else begin
          done_t d;
          d = dq.pop_front();
          chk("done_owner", {31'h0, dma_done}, {31'h0, d.dma});
          chk("done_cycle", cyc, d.cyc);
          if (d.chk_rd) chk("done_rdata", d.dma ? dma_rdata : cpu_rdata, d.rdata);
        end
      end
    end
  end

  // Raise a CPU request in the current cycle and queue what it must produce
  task automatic cpu_issue(input logic we, input logic [1:0] typ, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be, input logic [31:0] wd_exp,
                           input logic [31:0] rd_exp);
    wr_t w; done_t d;
    @(posedge clk); #1;
    cpu_we = we; cpu_type = typ; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    if (we) begin
      w.addr = {addr[31:2], 2'b00}; w.wdata = wd_exp; w.be = be; w.cyc = cyc + 2;
      wq.push_back(w);
    end
    d.dma = 1'b0; d.chk_rd = !we; d.rdata = rd_exp; d.cyc = cyc + 3;
    dq.push_back(d);
  endtask

  task automatic wait_done(input bit dma, input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (dma ? dma_done : cpu_done) seen = 1;
    end
    if (!seen) begin
      nchk++; nerr++;
      $display("FAIL done_timeout: dma %0b after %0d cycles", dma, limit);
    end
  endtask

  task automatic cpu_op(input logic we, input logic [1:0] typ, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] wd_exp,
                        input logic [31:0] rd_exp);
    cpu_issue(we, typ, addr, wd, be, wd_exp, rd_exp);
    wait_done(1'b0, 10);
    @(posedge clk); #1 cpu_req = 1'b0;
  endtask

  task automatic dma_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd_exp);
    wr_t w; done_t d;
    @(posedge clk); #1;
    dma_we = we; dma_addr = addr; dma_wdata = wd; dma_req = 1'b1;
    if (we) begin
      w.addr = {addr[31:2], 2'b00}; w.wdata = wd; w.be = 4'b1111; w.cyc = cyc + 2;
      wq.push_back(w);
    end
    d.dma = 1'b1; d.chk_rd = !we; d.rdata = rd_exp; d.cyc = cyc + 3;
    dq.push_back(d);
    wait_done(1'b1, 10);
    @(posedge clk); #1 dma_req = 1'b0;
  endtask

  initial begin
    int n;
    wr_t w; done_t d;
    // Reset state
    #2;
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_byteen", {28'h0, mem_byteen}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_done", {30'h0, cpu_done, dma_done}, 32'h0);
    chk("rst_stall_exc", {30'h0, cpu_stall, cpu_exc}, 32'h0);
    chk("rst_rdata", cpu_rdata | dma_rdata, 32'h0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    // Word store: write at t+2, done at t+3
    cpu_op(1'b1, DM_sw, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0);
    // Byte and halfword lane steering
    cpu_op(1'b1, DM_sb, 32'h13, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 32'h0);
    cpu_op(1'b1, DM_sb, 32'h11, 32'h0000003C, 4'b0010, 32'h3C3C3C3C, 32'h0);
    cpu_op(1'b1, DM_sh, 32'h12, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 32'h0);
    cpu_op(1'b1, DM_sh, 32'h10, 32'h00001234, 4'b0011, 32'h12341234, 32'h0);

    // Word load: stall high t..t+2, low at done
    mem_rdata = 32'h12345678;
    cpu_issue(1'b0, DM_sw, 32'h20, 32'h0, 4'b0000, 32'h0, 32'h12345678);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("load_stall", {31'h0, cpu_stall}, (k < 3) ? 32'h1 : 32'h0);
    end
    @(posedge clk); #1 cpu_req = 1'b0;

    // DMA write (address low bits dropped) and read; CPU read data holds
    dma_op(1'b1, 32'h47, 32'h0A0B0C0D, 32'h0);
    mem_rdata = 32'h0BADF00D;
    dma_op(1'b0, 32'h84, 32'h0, 32'h0BADF00D);
    chk("cpu_rdata_hold", cpu_rdata, 32'h12345678);

    // Starvation guard: three CPU grants while DMA waits, then DMA, then CPU again
    mem_rdata = 32'hCAFE0001;
    @(posedge clk); #1;
    cpu_we = 0; cpu_type = DM_sw; cpu_addr = 32'h30; cpu_req = 1'b1;
    dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'h11112222; dma_req = 1'b1;
    n = cyc;
    for (int k = 0; k < 3; k++) begin
      d.dma = 0; d.chk_rd = 1; d.rdata = 32'hCAFE0001; d.cyc = n + 3 + 4*k; dq.push_back(d);
    end
    d.dma = 1; d.chk_rd = 0; d.rdata = 32'h0; d.cyc = n + 15; dq.push_back(d);
    d.dma = 0; d.chk_rd = 1; d.rdata = 32'hCAFE0001; d.cyc = n + 19; dq.push_back(d);
    w.addr = 32'h80; w.wdata = 32'h11112222; w.be = 4'b1111; w.cyc = n + 14; wq.push_back(w);
    wait_done(1'b1, 30);
    @(posedge clk); #1 dma_req = 1'b0;
    wait_done(1'b0, 10);
    @(posedge clk); #1 cpu_req = 1'b0;
    chk("streak_cleared", {30'h0, dut.streak_q}, 32'h0);

    // Reset in BUSY: strobe drops at once, no done pulse afterwards
    @(posedge clk); #1;
    cpu_we = 1; cpu_type = DM_sw; cpu_addr = 32'h40; cpu_wdata = 32'h55; cpu_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_we_before_rst", {31'h0, mem_we}, 32'h1);
    reset = 1'b1; #1;
    chk("rst_mid_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mid_done", {31'h0, cpu_done}, 32'h0);
    cpu_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("idle_after_rst", {30'h0, dut.state_q}, {30'h0, MA_IDLE});

`ifdef ALIGN_CHK_EN
    // Misaligned word store is flagged and never reaches memory
    @(posedge clk); #1;
    cpu_we = 1; cpu_type = DM_sw; cpu_addr = 32'h02; cpu_wdata = 32'h77; cpu_req = 1'b1;
    #1;
    chk("exc_flag", {31'h0, cpu_exc}, 32'h1);
    chk("exc_stall", {31'h0, cpu_stall}, 32'h0);
    repeat (6) @(posedge clk);
    #1 chk("exc_idle", {30'h0, dut.state_q}, {30'h0, MA_IDLE});
    cpu_req = 1'b0;
`else
    // Without the check a misaligned word store proceeds as an aligned word write
    cpu_issue(1'b1, DM_sw, 32'h02, 32'h77, 4'b1111, 32'h77, 32'h0);
    #1;
    chk("noexc_flag", {31'h0, cpu_exc}, 32'h0);
    chk("noexc_stall", {31'h0, cpu_stall}, 32'h1);
    wait_done(1'b0, 10);
    @(posedge clk); #1 cpu_req = 1'b0;
`endif

    repeat (3) @(posedge clk);
    chk("queues_drained", dq.size() + wq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
